// File: rtl/inst_fetch_bus_if_pkg.sv
// Shared encodings and widths for the instruction-fetch bus responder.
// State encodings, pipeline constants and the default abort timeout.
package inst_fetch_bus_if_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned SEL_W      = 4;
    localparam int unsigned STALL_W    = 6;
    localparam int unsigned CNT_W      = 8;
    localparam int unsigned STALL_IFID = 1;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

    localparam logic [DATA_W-1:0] ZERO_WORD   = '0;
    localparam logic              CHIP_ENABLE = 1'b1;
    localparam logic              RST_ENABLE  = 1'b1;
    localparam logic [SEL_W-1:0]  SEL_ALL     = 4'hF;

    typedef enum logic [1:0] {
        WB_IDLE           = 2'b00,
        WB_BUSY           = 2'b01,
        WB_WAIT_FOR_STALL = 2'b11
    } wb_state_t;

endpackage

// File: rtl/inst_fetch_bus_if_if.sv
// Instruction bus bundle between the fetch responder (master) and memory (slave).
// bus_err_o exists only when FETCH_TIMEOUT_EN is defined.
interface inst_fetch_bus_if_if;
    import inst_fetch_bus_if_pkg::*;

    logic [ADDR_W-1:0] bus_addr_o;
    logic              bus_cyc_o;
    logic              bus_stb_o;
    logic              bus_we_o;
    logic [SEL_W-1:0]  bus_sel_o;
    logic [DATA_W-1:0] bus_data_i;
    logic              bus_ack_i;
`ifdef FETCH_TIMEOUT_EN
    logic              bus_err_o;
`endif

    modport master (
        output bus_addr_o, bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o,
`ifdef FETCH_TIMEOUT_EN
        output bus_err_o,
`endif
        input  bus_data_i, bus_ack_i
    );

    modport slave (
        input  bus_addr_o, bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o,
`ifdef FETCH_TIMEOUT_EN
        input  bus_err_o,
`endif
        output bus_data_i, bus_ack_i
    );

endinterface

// File: rtl/inst_fetch_bus_if.sv
// Single-beat instruction-fetch bus responder with pipeline stall request.
// Optional FETCH_TIMEOUT_EN aborts an unacknowledged fetch after TIMEOUT_CYCLES.
module inst_fetch_bus_if
    import inst_fetch_bus_if_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ce_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [STALL_W-1:0]  stall_i,
    input  logic                flush_i,
    output logic [DATA_W-1:0]   data_o,
    output logic                stallreq_o,
    inst_fetch_bus_if_if.master bus
);

    wb_state_t         state;
    logic [DATA_W-1:0] rd_buf;
    logic              ifid_stall;
    logic              timeout_hit;
    logic [DATA_W-1:0] data_c;
    logic              stallreq_c;
    logic              err_c;
    logic [4:0]        unused_stall;

    assign ifid_stall   = stall_i[STALL_IFID];
    assign unused_stall = {stall_i[5:2], stall_i[0]};

`ifdef FETCH_TIMEOUT_EN
    logic [CNT_W-1:0] wait_cnt;

    // Counts unacknowledged BUSY cycles; zero on every BUSY entry
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE || state != WB_BUSY || flush_i) begin
            wait_cnt <= '0;
        end else if (!bus.bus_ack_i) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign timeout_hit = (state == WB_BUSY) && !bus.bus_ack_i
                       && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus.bus_err_o = err_c;
`else
    logic [CNT_W-1:0] unused_timeout;
    assign unused_timeout = CNT_W'(TIMEOUT_CYCLES);
    assign timeout_hit    = 1'b0;
`endif

    assign bus.bus_we_o = 1'b0;

    // FSM with registered bus outputs; flush has priority over an ack
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state          <= WB_IDLE;
            bus.bus_addr_o <= '0;
            bus.bus_cyc_o  <= 1'b0;
            bus.bus_stb_o  <= 1'b0;
            bus.bus_sel_o  <= '0;
            rd_buf         <= ZERO_WORD;
        end else if (flush_i) begin
            state          <= WB_IDLE;
            bus.bus_addr_o <= '0;
            bus.bus_cyc_o  <= 1'b0;
            bus.bus_stb_o  <= 1'b0;
            bus.bus_sel_o  <= '0;
        end else begin
            case (state)
                WB_IDLE: begin
                    if (ce_i == CHIP_ENABLE) begin
                        bus.bus_addr_o <= addr_i;
                        bus.bus_cyc_o  <= 1'b1;
                        bus.bus_stb_o  <= 1'b1;
                        bus.bus_sel_o  <= SEL_ALL;
                        state          <= WB_BUSY;
                    end
                end
                WB_BUSY: begin
                    if (bus.bus_ack_i) begin
                        bus.bus_cyc_o <= 1'b0;
                        bus.bus_stb_o <= 1'b0;
                        bus.bus_sel_o <= '0;
                        rd_buf        <= bus.bus_data_i;
                        state         <= ifid_stall ? WB_WAIT_FOR_STALL : WB_IDLE;
                    end else if (timeout_hit) begin
                        bus.bus_addr_o <= '0;
                        bus.bus_cyc_o  <= 1'b0;
                        bus.bus_stb_o  <= 1'b0;
                        bus.bus_sel_o  <= '0;
                        state          <= WB_IDLE;
                    end
                end
                WB_WAIT_FOR_STALL: begin
                    if (!ifid_stall) begin
                        state <= WB_IDLE;
                    end
                end
                default: state <= WB_IDLE;
            endcase
        end
    end

    // Data and stall request respond in the same cycle as the request/ack
    always_comb begin
        data_c     = ZERO_WORD;
        stallreq_c = 1'b0;
        err_c      = 1'b0;
        if (rst != RST_ENABLE && !flush_i) begin
            case (state)
                WB_IDLE: stallreq_c = (ce_i == CHIP_ENABLE);
                WB_BUSY: begin
                    if (bus.bus_ack_i) begin
                        data_c = bus.bus_data_i;
                    end else if (timeout_hit) begin
                        err_c = 1'b1;
                    end else begin
                        stallreq_c = 1'b1;
                    end
                end
                WB_WAIT_FOR_STALL: data_c = rd_buf;
                default: data_c = ZERO_WORD;
            endcase
        end
    end

    assign data_o     = data_c;
    assign stallreq_o = stallreq_c;

endmodule

// File: tb/tb_inst_fetch_bus_if.sv
// Directed bench for inst_fetch_bus_if: per-cycle vector table plus corner sequences.
// Build with FETCH_TIMEOUT_EN to include the abort sequence.
module tb_inst_fetch_bus_if;
    import inst_fetch_bus_if_pkg::*;

    logic        clk;
    logic        rst;
    logic        ce_i;
    logic [31:0] addr_i;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic [31:0] data_o;
    logic        stallreq_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    inst_fetch_bus_if_if bif ();

    inst_fetch_bus_if #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .ce_i       (ce_i),
        .addr_i     (addr_i),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .data_o     (data_o),
        .stallreq_o (stallreq_o),
        .bus        (bif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        r;
        logic        ce;
        logic [31:0] a;
        logic [5:0]  st;
        logic        fl;
        logic [31:0] bd;
        logic        ack;
        logic [31:0] e_data;
        logic        e_sreq;
        logic [31:0] e_addr;
        logic        e_cyc;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else pass_cnt++;
    endtask

    task automatic add(input string nm, input logic r, input logic ce, input logic [31:0] a,
                       input logic [5:0] st, input logic fl, input logic [31:0] bd, input logic ack,
                       input logic [31:0] ed, input logic es, input logic [31:0] ea, input logic ec);
        vec_t v;
        v = '{nm, r, ce, a, st, fl, bd, ack, ed, es, ea, ec};
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic ce, input logic [31:0] a, input logic [5:0] st,
                         input logic fl, input logic [31:0] bd, input logic ack);
        rst = r; ce_i = ce; addr_i = a; stall_i = st; flush_i = fl;
        bif.bus_data_i = bd; bif.bus_ack_i = ack;
    endtask

    initial begin
        int stalls;
        int busy;
        logic done;

        //   name          rst ce addr          stall    fl data          ack  exp_data      sreq exp_addr     cyc
        add("reset_idle",  0, 0, 32'h0,        6'h00, 0, 32'h0,        0, 32'h00000000, 0, 32'h00000000, 0);
        add("zw_req",      0, 1, 32'h1FC00000, 6'h00, 0, 32'h0,        0, 32'h00000000, 1, 32'h00000000, 0);
        add("zw_ack",      0, 0, 32'h0,        6'h00, 0, 32'h3C011234, 1, 32'h3C011234, 0, 32'h1FC00000, 1);
        add("zw_idle",     0, 0, 32'h0,        6'h00, 0, 32'h0,        0, 32'h00000000, 0, 32'h1FC00000, 0);
        add("ws_req",      0, 1, 32'h00400000, 6'h00, 0, 32'h0,        0, 32'h00000000, 1, 32'h1FC00000, 0);
        add("ws_wait1",    0, 1, 32'h00400000, 6'h00, 0, 32'hDEADBEEF, 0, 32'h00000000, 1, 32'h00400000, 1);
        add("ws_wait2",    0, 1, 32'h00400000, 6'h00, 0, 32'hDEADBEEF, 0, 32'h00000000, 1, 32'h00400000, 1);
        add("ws_wait3",    0, 1, 32'h00400000, 6'h00, 0, 32'hDEADBEEF, 0, 32'h00000000, 1, 32'h00400000, 1);
        add("ws_ack",      0, 0, 32'h0,        6'h00, 0, 32'h8C220004, 1, 32'h8C220004, 0, 32'h00400000, 1);
        add("ws_idle",     0, 0, 32'h0,        6'h00, 0, 32'h0,        0, 32'h00000000, 0, 32'h00400000, 0);
        add("ds_req",      0, 1, 32'h00400004, 6'h00, 0, 32'h0,        0, 32'h00000000, 1, 32'h00400000, 0);
        add("ds_ack",      0, 0, 32'h0,        6'h03, 0, 32'hAC430008, 1, 32'hAC430008, 0, 32'h00400004, 1);
        add("ds_hold1",    0, 0, 32'h0,        6'h03, 0, 32'h0,        0, 32'hAC430008, 0, 32'h00400004, 0);
        add("ds_hold2",    0, 0, 32'h0,        6'h03, 0, 32'h0,        0, 32'hAC430008, 0, 32'h00400004, 0);
        add("ds_release",  0, 0, 32'h0,        6'h00, 0, 32'h0,        0, 32'hAC430008, 0, 32'h00400004, 0);
        add("ds_idle",     0, 0, 32'h0,        6'h00, 0, 32'h0,        0, 32'h00000000, 0, 32'h00400004, 0);
        add("fl_req",      0, 1, 32'h00400008, 6'h00, 0, 32'h0,        0, 32'h00000000, 1, 32'h00400004, 0);
        add("fl_collide",  0, 1, 32'h00400008, 6'h00, 1, 32'h12345678, 1, 32'h00000000, 0, 32'h00400008, 1);
        add("fl_after",    0, 0, 32'h0,        6'h00, 0, 32'h0,        0, 32'h00000000, 0, 32'h00000000, 0);
        add("fl_idle_ce",  0, 1, 32'h0040000C, 6'h00, 1, 32'h0,        0, 32'h00000000, 0, 32'h00000000, 0);
        add("fl_no_start", 0, 0, 32'h0,        6'h00, 0, 32'h0,        0, 32'h00000000, 0, 32'h00000000, 0);
        add("rs_req",      0, 1, 32'h00400010, 6'h00, 0, 32'h0,        0, 32'h00000000, 1, 32'h00000000, 0);
        add("rs_assert",   1, 0, 32'h0,        6'h00, 0, 32'h0,        0, 32'h00000000, 0, 32'h00400010, 1);
        add("rs_late_ack", 0, 0, 32'h0,        6'h00, 0, 32'hFFFFFFFF, 1, 32'h00000000, 0, 32'h00000000, 0);
        add("bb_req1",     0, 1, 32'h00000100, 6'h00, 0, 32'h0,        0, 32'h00000000, 1, 32'h00000000, 0);
        add("bb_ack1",     0, 1, 32'h00000100, 6'h00, 0, 32'h11111111, 1, 32'h11111111, 0, 32'h00000100, 1);
        add("bb_gap",      0, 1, 32'h00000104, 6'h00, 0, 32'h0,        0, 32'h00000000, 1, 32'h00000100, 0);
        add("bb_ack2",     0, 1, 32'h00000104, 6'h00, 0, 32'h22222222, 1, 32'h22222222, 0, 32'h00000104, 1);
        add("bb_idle",     0, 0, 32'h0,        6'h00, 0, 32'h0,        0, 32'h00000000, 0, 32'h00000104, 0);

        drive(1, 0, 32'h0, 6'h00, 0, 32'h0, 0);
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            drive(vecs[i].r, vecs[i].ce, vecs[i].a, vecs[i].st, vecs[i].fl, vecs[i].bd, vecs[i].ack);
            @(negedge clk);
            chk({vecs[i].nm, ".data"},     data_o,                   vecs[i].e_data);
            chk({vecs[i].nm, ".stallreq"}, 32'(stallreq_o),          32'(vecs[i].e_sreq));
            chk({vecs[i].nm, ".addr"},     bif.bus_addr_o,           vecs[i].e_addr);
            chk({vecs[i].nm, ".cyc"},      32'(bif.bus_cyc_o),       32'(vecs[i].e_cyc));
            chk({vecs[i].nm, ".stb"},      32'(bif.bus_stb_o),       32'(vecs[i].e_cyc));
            chk({vecs[i].nm, ".sel"},      32'(bif.bus_sel_o),       vecs[i].e_cyc ? 32'hF : 32'h0);
            chk({vecs[i].nm, ".we"},       32'(bif.bus_we_o),        32'h0);
        end

        // Flush-collision must leave the previously captured word in the read buffer
        @(posedge clk); #1; drive(0, 1, 32'h00000200, 6'h00, 0, 32'h0, 0);
        @(posedge clk); #1; drive(0, 0, 32'h0, 6'h00, 0, 32'h5555AAAA, 1);
        @(posedge clk); #1; drive(0, 1, 32'h00000204, 6'h00, 0, 32'h0, 0);
        @(posedge clk); #1; drive(0, 0, 32'h0, 6'h00, 1, 32'h99999999, 1);
        @(negedge clk);
        chk("flc.data", data_o, 32'h0);
        @(posedge clk); #1; drive(0, 0, 32'h0, 6'h00, 0, 32'h0, 0);
        @(negedge clk);
        chk("flc.rd_buf", dut.rd_buf, 32'h5555AAAA);
        chk("flc.state",  32'(dut.state), 32'(WB_IDLE));

        // Two-wait-state fetch with a bounded wait for the ack cycle
        @(posedge clk); #1; drive(0, 1, 32'h00000300, 6'h00, 0, 32'h0, 0);
        @(negedge clk);
        stalls = stallreq_o ? 1 : 0;
        busy = 0;
        done = 1'b0;
        for (int k = 0; k < 16 && !done; k++) begin
            @(posedge clk); #1;
            drive(0, 0, 32'h0, 6'h00, 0, (busy == 2) ? 32'h0BADF00D : 32'hCAFECAFE, busy == 2);
            @(negedge clk);
            if (stallreq_o) stalls++;
            if (bif.bus_ack_i) begin
                chk("ws2.data", data_o, 32'h0BADF00D);
                done = 1'b1;
            end else begin
                chk("ws2.stb",  32'(bif.bus_stb_o), 32'h1);
                chk("ws2.addr", bif.bus_addr_o, 32'h00000300);
                busy++;
            end
        end
        chk("ws2.acked", 32'(done), 32'h1);
        chk("ws2.stall_cycles", 32'(stalls), 32'd3);
        @(posedge clk); #1; drive(0, 0, 32'h0, 6'h00, 0, 32'h0, 0);

`ifdef FETCH_TIMEOUT_EN
        // Abort after four unacknowledged cycles: single err pulse, bus released
        @(posedge clk); #1; drive(0, 1, 32'h00000400, 6'h00, 0, 32'h0, 0);
        @(negedge clk);
        chk("to.err_idle", 32'(bif.bus_err_o), 32'h0);
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1; drive(0, 0, 32'h0, 6'h00, 0, 32'h0, 0);
            @(negedge clk);
            chk($sformatf("to.err_c%0d", c),  32'(bif.bus_err_o), (c == 4) ? 32'h1 : 32'h0);
            chk($sformatf("to.sreq_c%0d", c), 32'(stallreq_o),    (c < 4)  ? 32'h1 : 32'h0);
            chk($sformatf("to.data_c%0d", c), data_o, 32'h0);
            chk($sformatf("to.cyc_c%0d", c),  32'(bif.bus_cyc_o), (c <= 4) ? 32'h1 : 32'h0);
        end
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/inst_fetch_bus_if.md
# inst_fetch_bus_if

Instruction-fetch bus responder for the 5-stage MIPS core. It accepts the physical fetch address and chip-enable from the PC stage and runs a single-beat read handshake on the instruction bus. It returns the fetched word to IF/ID and holds the pipeline through `stallreq_o` until the word is available. Exception flushes discard in-flight fetches.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: bus cycles without ack before abort; used only under `FETCH_TIMEOUT_EN`.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ce_i` in 1: fetch request from the PC stage; chip enable is `1'b1`.
- `addr_i` in 32: physical fetch address, word-aligned.
- `stall_i` in 6: pipeline stall vector; bit 1 set means IF/ID is held.
- `flush_i` in 1: exception flush.
- `data_o` out 32: fetched instruction to IF/ID.
- `stallreq_o` out 1: fetch stall request to the stall controller.
- `bus_addr_o` out 32: bus address.
- `bus_cyc_o` out 1: bus cycle active.
- `bus_stb_o` out 1: bus strobe.
- `bus_we_o` out 1: write enable; constant 0.
- `bus_sel_o` out 4: byte select; `4'b1111` during a cycle, otherwise 0.
- `bus_data_i` in 32: read data.
- `bus_ack_i` in 1: read acknowledge.
- `bus_err_o` out 1: fetch-abort pulse; present only under `FETCH_TIMEOUT_EN`.

## Operation
- Reset values:
  - FSM state `IDLE`.
  - `bus_addr_o`, `bus_cyc_o`, `bus_stb_o`, `bus_sel_o`, `bus_we_o` all 0.
  - Read buffer `rd_buf` = 0.
  - `data_o` = 0, `stallreq_o` = 0, `bus_err_o` = 0.
- FSM states: `IDLE`, `BUSY`, `WAIT_FOR_STALL`.
- `IDLE`:
  - Entry condition for a fetch: `ce_i`=1 and `flush_i`=0.
  - On that condition: register `bus_addr_o`=`addr_i`, `bus_cyc_o`=`bus_stb_o`=1, `bus_sel_o`=`4'hF`; next state `BUSY`.
  - `stallreq_o` is combinationally 1 whenever `ce_i`=1 and `flush_i`=0.
  - `data_o`=0.
- `BUSY`:
  - Bus outputs held stable until ack.
  - Without ack: `stallreq_o`=1, `data_o`=0.
  - On `bus_ack_i`=1:
    - Clear `bus_cyc_o`, `bus_stb_o`, `bus_sel_o`.
    - Capture `bus_data_i` into `rd_buf`.
    - In the same cycle, `stallreq_o`=0 and `data_o`=`bus_data_i` combinationally.
    - Next state is `WAIT_FOR_STALL` if `stall_i[1]`=1, else `IDLE`.
- `WAIT_FOR_STALL`:
  - `data_o`=`rd_buf`, `stallreq_o`=0.
  - When `stall_i[1]`=0, go to `IDLE`.
- Flush in any state:
  - Bus outputs cleared next edge; next state `IDLE`.
  - `stallreq_o`=0; `data_o`=0.
  - Flush wins over a simultaneous `bus_ack_i`: the acked data is discarded.
- `ce_i` dropping while `BUSY`: the cycle still completes; the result is buffered per normal rules.
- `rst` asserted mid-cycle: abandon the bus cycle and force reset values next edge. A late ack after reset is ignored.

## Timing
- Fetch latency: `ce_i` sampled in `IDLE` at edge N, strobe visible after N. A zero-wait-state slave acks in cycle N+1, and data appears on `data_o` in that same cycle.
- `stallreq_o` is high from request until the ack cycle; a zero-wait fetch stalls for exactly one cycle.
- New fetch cycles start only from `IDLE`; there is at most one outstanding fetch.
- Back-to-back fetches: one idle bus cycle between consecutive strobes (the `IDLE` entry cycle).

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - An 8-bit wait counter, sized for `TIMEOUT_CYCLES` ≤ 255, clears on entry to `BUSY`.
  - If it reaches `TIMEOUT_CYCLES` with no ack: clear bus outputs and go to `IDLE`.
  - In that cycle: `data_o`=`32'h00000000` (NOP), `stallreq_o`=0, `bus_err_o`=1 for one cycle.
  - The core maps `bus_err_o` into the fetch exception type.
- `FETCH_TIMEOUT_EN` undefined: no counter, no `bus_err_o` port; `BUSY` waits indefinitely.

## Structure
- In `defines.v`:
  - 2-bit state encodings `WB_IDLE`, `WB_BUSY`, `WB_WAIT_FOR_STALL`.
  - `ZeroWord`, `ChipEnable`, `RstEnable`.
  - Stall-vector bit index for IF/ID.
  - Default for `TIMEOUT_CYCLES`.
- No sub-module. FSM, read buffer and optional counter live flat in one module.

## Test plan
- Zero-wait fetch: reset, then `ce_i`=1, `addr_i`=`32'h1FC00000`; slave acks the next cycle with `32'h3C011234`. Required: `bus_addr_o`=`32'h1FC00000`; same-cycle `data_o`=`32'h3C011234`; `stallreq_o` high exactly 1 cycle.
- Wait states: ack delayed 3 cycles. Required: `stallreq_o` high 4 cycles, `bus_stb_o` stable throughout, data returned correctly.
- Downstream stall: ack arrives while `stall_i`=`6'b000011`, held 2 cycles. Required: `data_o` holds the acked word from `rd_buf` both cycles, then returns to `IDLE`.
- Flush collision: `flush_i`=1 in the same cycle as `bus_ack_i`. Required: `data_o`=0, `stallreq_o`=0, state `IDLE`, no capture into `rd_buf`.
- Reset mid-cycle: `rst`=1 while `BUSY`, then a late ack. Required: all outputs 0 next edge; late ack ignored.
- `FETCH_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, no ack. Required: `bus_err_o` pulses once on cycle 4, `data_o`=0, bus released.
